mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
// - Multicycle signed MULT/DIV responder. The control unit's MULT/DIV states are the initiator.
// - Takes operands from the A/B registers on a start pulse and iterates one bit per cycle.
// - Writes the HI/LO pair and pulses done; on a divide-by-zero it pulses div_zero to the control unit instead.
// PARAMETERS
// - WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
// - clk         in   1      rising-edge clock
// - reset       in   1      synchronous reset, active-low (0 = reset), sampled on rising clk
// - start_mult  in   1      request signed multiply; sampled only in IDLE
// - start_div   in   1      request signed divide; sampled only in IDLE
// - a_in        in   WIDTH  multiplicand / dividend
// - b_in        in   WIDTH  multiplier / divisor
// - hi          out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
// - lo          out  WIDTH  MULT: product[W-1:0]; DIV: quotient
// - busy        out  1      1 in every state except IDLE
// - done        out  1      1-cycle pulse; hi/lo are valid from this cycle on
// - div_zero    out  1      1-cycle pulse on a divide with b_in==0
// BEHAVIOUR
// - Reset (reset==0 on an edge): state IDLE; hi=lo=0; busy=done=div_zero=0.
//   - Reset mid-operation aborts the operation; no done is issued.
// - States: IDLE, MUL_RUN, DIV_RUN, FIX, DONE, DZ.
// - IDLE accept:
//   - On an edge with start_mult=1: latch a_in/b_in, counter=WIDTH-1, go to MUL_RUN.
//   - Else on an edge with start_div=1: latch a_in/b_in, go to DIV_RUN, or to DZ if b_in==0 and the macro is defined.
//   - Both starts high: mult wins; div is dropped.
//   - start is ignored in every state other than IDLE; there is no queueing.
// - MUL_RUN: radix-2 Booth step over a 2W+1 accumulator with arithmetic right shift.
// - DIV_RUN: restoring step on |a| and |b|.
// - Counter decrements each edge; at 0 go to FIX.
//   - The run state lasts WIDTH edges: accept edge E0 through E(WIDTH).
// - FIX:
//   - DIV: quotient negated if sign(a)^sign(b); remainder takes the sign of a, truncation toward zero.
//   - MULT: no correction.
//   - Load hi/lo; go to DONE.
// - DONE: done=1 for one cycle, then IDLE.
//   - done rises at edge E(WIDTH+2) = 34 edges after accept for W=32.
// - DZ: div_zero=1 for one cycle; hi/lo untouched; no done; go to IDLE.
// - Overflow: MIN_INT / -1 yields lo=MIN_INT, hi=0 (wrap); no flag.
// - hi/lo hold their last result until the next FIX or a reset.
// CONFIGURATION
// - Macro MULTDIV_DIVZERO_EXC_EN.
// - Defined:
//   - b_in==0 on a div start: IDLE -> DZ at E0; div_zero pulses in the cycle after accept.
//   - hi/lo unchanged.
// - Undefined:
//   - div_zero tied 0; the divide runs at normal latency.
//   - FIX forces lo='1 (all ones) and hi=a.
// STRUCTURE
// - Package mult_div_pkg:
//   - state localparams: IDLE=0, MUL_RUN=1, DIV_RUN=2, FIX=3, DONE=4, DZ=5
//   - op select (OP_MULT, OP_DIV)
//   - MULTDIV_WIDTH default 32
// - Sub-module div_step (combinational): one restoring iteration.
//   - Inputs: remainder, quotient, divisor.
//   - Outputs: next remainder and next quotient.
// TESTING
// 1. mult 7 x -3 -> done at edge 34 after accept; hi=FFFFFFFF, lo=FFFFFFEB; busy 1 for edges 1..34.
// 2. mult 80000000 x 80000000 -> hi=40000000, lo=00000000.
// 3. div -7 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF; div 80000000 / FFFFFFFF -> lo=80000000, hi=0.
// 4. div 5 / 0:
//    - EN defined: div_zero pulse in the cycle after accept; no done; hi/lo keep prior values.
//    - EN undefined: done at 34; lo=FFFFFFFF, hi=5.
// 5. start_mult and start_div together (3,2) -> product hi=0, lo=6; a start pulse mid-run is ignored and result unchanged.
// 6. reset=0 at run edge 10 -> next cycle state IDLE, busy=0, hi=lo=0, no done; a new mult then completes normally.

Source files
------------

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared types and constants for the signed multiply/divide unit.
//   - mdu_state_t : FSM state encoding (IDLE=0, MUL_RUN=1, DIV_RUN=2, FIX=3, DONE=4, DZ=5)
//   - mdu_op_t    : operation latched at accept (OP_MULT / OP_DIV)
//   - MULTDIV_WIDTH : default operand width
package mult_div_pkg;

  localparam int MULTDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_RUN = 3'd1,
    DIV_RUN = 3'd2,
    FIX     = 3'd3,
    DONE    = 3'd4,
    DZ      = 3'd5
  } mdu_state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } mdu_op_t;

endpackage

// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the control unit (master) and
// the multiply/divide unit (slave).
//   start_mult, start_div : request pulses (master -> slave)
//   a_in, b_in            : operands (master -> slave)
//   hi, lo                : result pair (slave -> master)
//   busy, done, div_zero  : status (slave -> master)
interface mult_div_if #(
  parameter int WIDTH = mult_div_pkg::MULTDIV_WIDTH
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start_mult, start_div, a_in, b_in,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, a_in, b_in,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// div_step: one combinational restoring-division iteration on unsigned values.
//   i_rem : partial remainder      o_rem : next partial remainder
//   i_quo : dividend/quotient reg  o_quo : next dividend/quotient reg
//   i_dvs : divisor (magnitude)
// The dividend bits are shifted out of the top of the quotient register while
// quotient bits are shifted in at the bottom.
module div_step #(
  parameter int WIDTH = mult_div_pkg::MULTDIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Trial subtraction; an extra top bit catches the borrow.
  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_dvs};
    if (!w_diff[WIDTH]) begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed MULT/DIV responder, one bit per cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous reset, active-low
//   bus   : mult_div_if.slave (start_mult, start_div, a_in, b_in -> hi, lo,
//           busy, done, div_zero)
// Config macro MULTDIV_DIVZERO_EXC_EN:
//   defined   : divide by zero goes IDLE -> DZ and pulses div_zero, hi/lo kept
//   undefined : div_zero tied 0; divide by zero runs normally and FIX loads
//               lo = all ones, hi = dividend
// Timing: accept at E0, run E1..E(WIDTH), FIX at E(WIDTH+1) loads hi/lo,
// DONE at E(WIDTH+2) raises done for one cycle.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MULTDIV_WIDTH
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t       r_state;
  mdu_op_t          r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Booth accumulator: A carries one guard bit so MIN_INT multiplicands
  // cannot overflow the partial sum; Q holds the multiplier, r_qm1 is q(-1).
  logic [WIDTH:0]   r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_qm1;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  logic [WIDTH:0]   w_mcand;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_signed;
  logic [WIDTH-1:0] w_rem_signed;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign w_mcand = {r_a[WIDTH-1], r_a};

  // Booth add/subtract selection from the current multiplier bit pair.
  always_comb begin
    case ({r_acc_lo[0], r_qm1})
      2'b01:   w_booth_sum = r_acc_hi + w_mcand;
      2'b10:   w_booth_sum = r_acc_hi - w_mcand;
      default: w_booth_sum = r_acc_hi;
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // Sign correction and result selection loaded into hi/lo in FIX.
  always_comb begin
    w_quo_signed = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -r_quo : r_quo;
    w_rem_signed = r_a[WIDTH-1] ? -r_rem : r_rem;
    if (r_op == OP_MULT) begin
      w_fix_hi = r_acc_hi[WIDTH-1:0];
      w_fix_lo = r_acc_lo;
    end else begin
`ifdef MULTDIV_DIVZERO_EXC_EN
      w_fix_hi = w_rem_signed;
      w_fix_lo = w_quo_signed;
`else
      if (r_b == {WIDTH{1'b0}}) begin
        w_fix_hi = r_a;
        w_fix_lo = {WIDTH{1'b1}};
      end else begin
        w_fix_hi = w_rem_signed;
        w_fix_lo = w_quo_signed;
      end
`endif
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_op       <= OP_MULT;
      r_cnt      <= {CNT_W{1'b0}};
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_acc_hi   <= {(WIDTH+1){1'b0}};
      r_acc_lo   <= {WIDTH{1'b0}};
      r_qm1      <= 1'b0;
      r_rem      <= {WIDTH{1'b0}};
      r_quo      <= {WIDTH{1'b0}};
      r_dvs      <= {WIDTH{1'b0}};
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_mult) begin
            r_a      <= bus.a_in;
            r_b      <= bus.b_in;
            r_acc_hi <= {(WIDTH+1){1'b0}};
            r_acc_lo <= bus.b_in;
            r_qm1    <= 1'b0;
            r_op     <= OP_MULT;
            r_cnt    <= CNT_W'(WIDTH-1);
            r_busy   <= 1'b1;
            r_state  <= MUL_RUN;
          end else if (bus.start_div) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_rem   <= {WIDTH{1'b0}};
            r_quo   <= f_abs(bus.a_in);
            r_dvs   <= f_abs(bus.b_in);
            r_op    <= OP_DIV;
            r_cnt   <= CNT_W'(WIDTH-1);
            r_busy  <= 1'b1;
`ifdef MULTDIV_DIVZERO_EXC_EN
            if (bus.b_in == {WIDTH{1'b0}}) begin
              r_div_zero <= 1'b1;
              r_state    <= DZ;
            end else begin
              r_state <= DIV_RUN;
            end
`else
            r_state <= DIV_RUN;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        MUL_RUN: begin
          // Arithmetic right shift of {A, Q, q(-1)} after the Booth add.
          r_acc_hi <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
          r_acc_lo <= {w_booth_sum[0], r_acc_lo[WIDTH-1:1]};
          r_qm1    <= r_acc_lo[0];
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_state <= FIX;
          end else begin
            r_state <= MUL_RUN;
          end
        end
        DIV_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_state <= FIX;
          end else begin
            r_state <= DIV_RUN;
          end
        end
        FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        DZ: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (WIDTH=32).
// Expected hi/lo come from native 64-bit signed arithmetic; results are
// popped and compared whenever done is seen.
module tb_mult_div_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   dz_seen;
  exp_t sb_q[$];
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mul) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else begin
      p  = sa / sb;
      el = p[31:0];
      p  = sa % sb;
      eh = p[31:0];
    end
  endtask

  // Drive one start pulse; returns #1 after the accept edge E0.
  task automatic issue(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic push);
    exp_t e;
    @(posedge clk); #1;
    bus.start_mult = m;
    bus.start_div  = d;
    bus.a_in       = a;
    bus.b_in       = b;
    if (push) begin
      model(m, a, b, e.hi, e.lo);
      sb_q.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(posedge clk); #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
  endtask

  // Count edges after accept until done; optionally pulse starts mid-run.
  task automatic wait_done(input string tag, input int pulse_at);
    int k;
    int bad;
    logic seen;
    k = 0; bad = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) bad++;
      if (pulse_at != 0 && k == pulse_at) begin
        bus.start_mult = 1'b1;
        bus.start_div  = 1'b1;
        bus.a_in       = 32'd9;
        bus.b_in       = 32'd9;
      end else begin
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
      end
    end
    chk({tag, "_latency"}, 64'(k), 64'd34);
    chk({tag, "_busy_run"}, 64'(bad), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  // Scoreboard: compare each done against the oldest expectation.
  always @(negedge clk) begin
    if (reset && bus.div_zero) dz_seen++;
    if (reset && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result_hi", 64'(bus.hi), 64'(e.hi));
        chk("result_lo", 64'(bus.lo), 64'(e.lo));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rm;
    n_vec = 0; n_err = 0; dz_seen = 0;
    last_hi = 32'd0; last_lo = 32'd0;
    reset = 1'b0;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a_in = 32'd0;
    bus.b_in = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    reset = 1'b1;

    // 1. mult 7 x -3 with latency/busy profile
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    chk("t1_busy_e0", 64'(bus.busy), 64'd1);
    wait_done("t1", 0);
    // 2. MIN_INT squared
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done("t2", 0);
    // 3. signed divides incl. overflow wrap
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("t3a", 0);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("t3b", 0);
    // 4. divide by zero
`ifdef MULTDIV_DIVZERO_EXC_EN
    issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b0);
    chk("t4_dz_pulse", 64'(bus.div_zero), 64'd1);
    chk("t4_busy_dz", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    chk("t4_dz_end", 64'(bus.div_zero), 64'd0);
    chk("t4_busy_end", 64'(bus.busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("t4_hi_kept", 64'(bus.hi), 64'(last_hi));
    chk("t4_lo_kept", 64'(bus.lo), 64'(last_lo));
    chk("t4_dz_count", 64'(dz_seen), 64'd1);
`else
    issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b1);
    wait_done("t4", 0);
    chk("t4_dz_count", 64'(dz_seen), 64'd0);
`endif
    // 5. both starts: mult wins; mid-run start pulse ignored
    issue(1'b1, 1'b1, 32'd3, 32'd2, 1'b1);
    wait_done("t5a", 0);
    issue(1'b1, 1'b0, 32'd100, 32'hFFFF_FFFB, 1'b1);
    wait_done("t5b", 10);
    repeat (40) @(posedge clk);
    #1;
    chk("t5_no_extra", 64'(sb_q.size()), 64'd0);
    // 6. reset mid-run aborts, then a new mult completes
    issue(1'b1, 1'b0, 32'd11, 32'd13, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_hi", 64'(bus.hi), 64'd0);
    chk("t6_lo", 64'(bus.lo), 64'd0);
    chk("t6_done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    issue(1'b1, 1'b0, 32'hFFFF_FF00, 32'd1234, 1'b1);
    wait_done("t6b", 0);
    // random mix (nonzero divisors)
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rm = 1'($urandom_range(1, 0));
      if (rb == 32'd0) rb = 32'd1;
      issue(rm, !rm, ra, rb, 1'b1);
      wait_done("rnd", 0);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
